// File: rtl/xnor_sweep_pkg.sv
// Shared types and constants for the 3-input XNOR sweep controller.
package xnor_sweep_pkg;
  typedef logic [1:0] state_t;

  localparam state_t S_IDLE   = 2'd0;
  localparam state_t S_APPLY  = 2'd1;
  localparam state_t S_FINISH = 2'd2;

  localparam int NUM_VEC  = 8;
  localparam int NUM_IMPL = 3;
  localparam int VEC_W    = $clog2(NUM_VEC);
  localparam int ERR_W    = $clog2(NUM_VEC + 1);

  localparam logic [VEC_W-1:0] LAST_VEC = 3'd7;

  function automatic logic golden_xnor(input logic [VEC_W-1:0] v);
    return ~^v;
  endfunction
endpackage

// File: rtl/xnor_sweep_ctrl_if.sv
// Stimulus/response and status bundle between the sweep controller and its surroundings.
interface xnor_sweep_ctrl_if;
  import xnor_sweep_pkg::*;

  logic                 start;
  logic [NUM_IMPL-1:0]  cmp_mask;
  logic [VEC_W-1:0]     vec;
  logic [NUM_IMPL-1:0]  z_in;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [ERR_W-1:0]     err_cnt;
  logic                 first_err_valid;
  logic [VEC_W-1:0]     first_err_vec;

  modport master (
    input  start, cmp_mask, z_in,
    output vec, busy, done, pass, err_cnt, first_err_valid, first_err_vec
  );

  modport slave (
    output start, cmp_mask, z_in,
    input  vec, busy, done, pass, err_cnt, first_err_valid, first_err_vec
  );
endinterface

// File: rtl/xnor_sweep_ctrl_hold_timer.sv
// Per-vector hold counter; expire_o marks the last cycle of a hold.
module hold_timer #(
  parameter int HOLD_CYCLES = 100,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic expire_o
);
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expire_o = (cnt_q == CNT_W'(HOLD_CYCLES - 1));
endmodule

// File: rtl/xnor_sweep_ctrl.sv
// Walks all 8 input vectors through the three XNOR implementations and
// scores their outputs against the golden XNOR on the last cycle of each hold.
module xnor_sweep_ctrl
  import xnor_sweep_pkg::*;
#(
  parameter int HOLD_CYCLES = 100,
  parameter int CNT_W       = 8
) (
  input logic              clk,
  input logic              rst,
  xnor_sweep_ctrl_if.master bus
);
  state_t              state_q, state_d;
  logic [VEC_W-1:0]    vec_q, vec_d;
  logic [NUM_IMPL-1:0] mask_q, mask_d;
  logic [ERR_W-1:0]    err_cnt_q, err_cnt_d;
  logic                pass_q, pass_d;
  logic                fev_q, fev_d;
  logic [VEC_W-1:0]    fevec_q, fevec_d;

  logic expire;
  logic sample;
  logic expected;
  logic mismatch;
  logic accept;

  // The counter is held at zero outside APPLY so each hold starts from a clean count.
  hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES),
    .CNT_W       (CNT_W)
  ) u_hold_timer (
    .clk      (clk),
    .rst      (rst),
    .clear_i  ((state_q != S_APPLY) || expire),
    .en_i     (state_q == S_APPLY),
    .expire_o (expire)
  );

  assign accept   = (state_q == S_IDLE) && bus.start;
  assign sample   = (state_q == S_APPLY) && expire;
  assign expected = golden_xnor(vec_q);
  assign mismatch = |((bus.z_in ^ {NUM_IMPL{expected}}) & mask_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.start) state_d = S_APPLY;
      S_APPLY:  if (sample && (vec_q == LAST_VEC)) state_d = S_FINISH;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state_q == S_APPLY);
    bus.done = (state_q == S_FINISH);
  end

  always_comb begin
    vec_d     = vec_q;
    mask_d    = mask_q;
    err_cnt_d = err_cnt_q;
    pass_d    = pass_q;
    fev_d     = fev_q;
    fevec_d   = fevec_q;
    if (accept) begin
      mask_d    = bus.cmp_mask;
      err_cnt_d = '0;
      pass_d    = 1'b0;
      fev_d     = 1'b0;
      fevec_d   = '0;
      vec_d     = '0;
    end
    if (sample) begin
      if (mismatch) begin
        err_cnt_d = err_cnt_q + 1'b1;
        if (!fev_q) begin
          fev_d   = 1'b1;
          fevec_d = vec_q;
        end
      end
      // pass is settled on the same edge that enters FINISH, alongside the final count.
      if (vec_q == LAST_VEC) begin
        vec_d  = '0;
        pass_d = (err_cnt_d == '0);
      end else begin
        vec_d = vec_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vec_q     <= '0;
      mask_q    <= '0;
      err_cnt_q <= '0;
      pass_q    <= 1'b0;
      fev_q     <= 1'b0;
      fevec_q   <= '0;
    end else begin
      vec_q     <= vec_d;
      mask_q    <= mask_d;
      err_cnt_q <= err_cnt_d;
      pass_q    <= pass_d;
      fev_q     <= fev_d;
      fevec_q   <= fevec_d;
    end
  end

  assign bus.vec             = vec_q;
  assign bus.pass            = pass_q;
  assign bus.err_cnt         = err_cnt_q;
  assign bus.first_err_valid = fev_q;
  assign bus.first_err_vec   = fevec_q;
endmodule

// File: tb/tb_xnor_sweep_ctrl.sv
// Directed bench for xnor_sweep_ctrl with a behavioural XNOR trio and injectable faults.
module tb_xnor_sweep_ctrl;
  localparam int HOLD = 4;
  localparam int LAT  = 8 * HOLD + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  xnor_sweep_ctrl_if bus ();

  logic stuck_z2;
  logic flip_z3_on5;
  logic golden;
  int   errors = 0;
  int   checks = 0;

  // z_in = {z3, z2, z1}
  assign golden  = ~^bus.vec;
  assign bus.z_in = {golden ^ (flip_z3_on5 && (bus.vec == 3'd5)),
                     golden & ~stuck_z2,
                     golden};

  xnor_sweep_ctrl #(
    .HOLD_CYCLES (HOLD),
    .CNT_W       (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulses start for one cycle, optionally re-pulses it at cycle dup_at, and
  // returns the cycle offset at which done was first seen (-1 if never).
  task automatic sweep(input logic [2:0] mask, input int dup_at, input bit chk_vec, output int lat);
    int c;
    @(negedge clk);
    bus.cmp_mask = mask;
    bus.start    = 1'b1;
    lat = -1;
    c   = 0;
    while ((c < LAT + 10) && (lat < 0)) begin
      @(negedge clk);
      c++;
      bus.start = (c == dup_at);
      if (chk_vec && (c <= 8 * HOLD)) begin
        check("vec_step", 32'(bus.vec), 32'((c - 1) / HOLD));
        check("busy_high", 32'(bus.busy), 32'd1);
      end
      if (bus.done) begin
        lat = c;
        check("busy_low_in_done", 32'(bus.busy), 32'd0);
        check("vec_zero_in_done", 32'(bus.vec), 32'd0);
      end
    end
    bus.start = 1'b0;
    check("done_latency", 32'(lat), 32'(LAT));
    @(negedge clk);
    check("done_one_cycle", 32'(bus.done), 32'd0);
  endtask

  task automatic results(input string tag, input logic p, input logic [3:0] ec,
                         input logic fv, input logic [2:0] fvec);
    check({tag, "_pass"}, 32'(bus.pass), 32'(p));
    check({tag, "_err_cnt"}, 32'(bus.err_cnt), 32'(ec));
    check({tag, "_fev"}, 32'(bus.first_err_valid), 32'(fv));
    check({tag, "_fevec"}, 32'(bus.first_err_vec), 32'(fvec));
    $display("sweep %s: pass=%0d err_cnt=%0d first_err_valid=%0d first_err_vec=%0d",
             tag, bus.pass, bus.err_cnt, bus.first_err_valid, bus.first_err_vec);
  endtask

  initial begin
    int lat;
    int ndone;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.cmp_mask = 3'b000;
    stuck_z2     = 1'b0;
    flip_z3_on5  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_vec", 32'(bus.vec), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    results("reset", 1'b0, 4'd0, 1'b0, 3'd0);

    // Clean sweep, full mask, vector stepping checked cycle by cycle.
    sweep(3'b111, 0, 1'b1, lat);
    results("clean", 1'b1, 4'd0, 1'b0, 3'd0);

    // z2 stuck-at-0 fails where expected=1: vec 0,3,5,6.
    stuck_z2 = 1'b1;
    sweep(3'b111, 0, 1'b0, lat);
    results("z2_sa0", 1'b0, 4'd4, 1'b1, 3'd0);

    // Same fault masked out; previous failure must be cleared.
    sweep(3'b101, 0, 1'b0, lat);
    results("z2_sa0_masked", 1'b1, 4'd0, 1'b0, 3'd0);
    stuck_z2 = 1'b0;

    // z3 inverted only on vec 5.
    flip_z3_on5 = 1'b1;
    sweep(3'b111, 0, 1'b0, lat);
    results("z3_flip5", 1'b0, 4'd1, 1'b1, 3'd5);

    // Empty mask compares clean even with a fault present.
    sweep(3'b000, 0, 1'b0, lat);
    results("mask0", 1'b1, 4'd0, 1'b0, 3'd0);
    flip_z3_on5 = 1'b0;

    // Reset at hold cycle 2 of vec 3 (cycle offset 15 after start edge).
    stuck_z2 = 1'b1;
    @(negedge clk);
    bus.cmp_mask = 3'b111;
    bus.start    = 1'b1;
    for (int c = 1; c <= 2 + 3 * HOLD + 1; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    check("pre_rst_vec", 32'(bus.vec), 32'd3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_vec", 32'(bus.vec), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_err", 32'(bus.err_cnt), 32'd0);
    ndone = 0;
    for (int c = 0; c < LAT + 5; c++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    check("no_done_after_rst", 32'(ndone), 32'd0);
    stuck_z2 = 1'b0;
    sweep(3'b111, 0, 1'b0, lat);
    results("after_rst", 1'b1, 4'd0, 1'b0, 3'd0);

    // Start re-pulsed mid-sweep must be ignored: one done at original latency.
    sweep(3'b111, 10, 1'b0, lat);
    ndone = 0;
    for (int c = 0; c < LAT + 5; c++) begin
      @(negedge clk);
      if (bus.done) ndone++;
      check("busy_stays_low", 32'(bus.busy), 32'd0);
    end
    check("single_done", 32'(ndone), 32'd0);
    results("dup_start", 1'b1, 4'd0, 1'b0, 3'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/xnor_sweep_ctrl.md
# xnor_sweep_ctrl

Self-checking sweep controller for the three 3-input XNOR implementations (structural, dataflow, behavioural). On a start pulse it walks the shared 3-bit input vector through all 8 combinations, holds each for a programmable number of cycles, and samples the three returned outputs against the golden value ~(j^k^l). It reports per-sweep pass/fail, a mismatch count and the first failing vector. It sits between the gate instances and the board-level status logic (LEDs or a debug register), replacing the hand-timed `#100` stimulus with synthesizable sequencing.

## Interface
Parameters:
- HOLD_CYCLES, 100: cycles each vector is held; legal range 1..2^CNT_W-1.
- CNT_W, 8: width of the hold counter.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a sweep.
- cmp_mask  in  3  bit i=1 includes implementation i in the compare; sampled at start.
- vec  out  3  {j,k,l} driven to all three gate instances.
- z_in  in  3  {z3,z2,z1} outputs returned from the instances.
- busy  out  1  high from the cycle after start is accepted through the last sample.
- done  out  1  one-cycle pulse when the sweep completes.
- pass  out  1  1 when the last completed sweep had err_cnt==0; held until the next start.
- err_cnt  out  4  number of vectors (0..8) with at least one masked mismatch.
- first_err_valid  out  1  set on the first mismatching vector of a sweep.
- first_err_vec  out  3  vec value at the first mismatch; valid when first_err_valid=1.

## Operation
- States: IDLE, APPLY, FINISH.
- IDLE: vec=0, busy=0. If start=1, latch cmp_mask, clear err_cnt, pass, first_err_valid and first_err_vec, set vec=0 and hc=0, then go to APPLY.
- APPLY: busy=1 and vec is held. hc increments each cycle.
  - At hc==HOLD_CYCLES-1 (sample cycle): expected=~(vec[2]^vec[1]^vec[0]); mismatch=|((z_in ^ {3{expected}}) & mask).
  - On mismatch: err_cnt+=1; if first_err_valid==0, latch first_err_vec=vec and set first_err_valid.
  - Same cycle: if vec==7 go to FINISH; else vec+=1 and hc=0.
- FINISH: done=1 for exactly one cycle, pass=(err_cnt==0), busy=0, vec returns to 0, then go to IDLE.
- start while busy or in FINISH is ignored; no queuing.
- Results (pass, err_cnt, first_err_*) persist in IDLE until the next accepted start.
- mask==0: every vector compares clean, so pass=1 and err_cnt=0.
- err_cnt saturates naturally: at most 8 increments into 4 bits, so no wrap.
- vec increment never wraps mid-sweep; 7 is terminal.

## Timing
- Reset values: state=IDLE, vec=0, busy=0, done=0, pass=0, err_cnt=0, first_err_valid=0, first_err_vec=0, hc=0.
- start accepted at edge t: vec=0 visible and busy=1 from cycle t+1.
- Vector n is driven over cycles t+1+n·HOLD_CYCLES .. t+(n+1)·HOLD_CYCLES.
- z_in is sampled combinationally on the last cycle of each hold; the gates are combinational off registered vec.
- done pulses at cycle t+8·HOLD_CYCLES+1. pass and err_cnt are final at the same edge done rises.
- Total sweep latency, start to done: 8·HOLD_CYCLES+1 cycles.
- rst mid-sweep: next edge returns to the full reset state. No done pulse; the partial results are discarded.

## Structure
- Package xnor_sweep_pkg:
  - state encoding localparams (S_IDLE, S_APPLY, S_FINISH).
  - NUM_VEC=8, NUM_IMPL=3, LAST_VEC=3'd7.
- Sub-module hold_timer:
  - CNT_W counter with clear and enable; asserts `expire` at HOLD_CYCLES-1.
  - Instantiated once; the FSM uses `expire` as its sample strobe.
- Golden-model compare is inline logic in the top module.

## Test plan
- All three implementations correct, HOLD_CYCLES=4, mask=3'b111, start pulse.
  - Required: vec steps 0..7 every 4 cycles.
  - Required: done at start+33; pass=1, err_cnt=0, first_err_valid=0.
- Force z2 stuck-at-0, mask=3'b111.
  - Required: mismatches where expected=1 (vec 0,3,5,6); err_cnt=4, pass=0, first_err_vec=0.
- Same stuck-at-0 fault, mask=3'b101.
  - Required: pass=1, err_cnt=0.
- Invert z3 on vec==5 only.
  - Required: err_cnt=1, first_err_vec=5, first_err_valid=1.
- Assert rst at hold cycle 2 of vec=3.
  - Required: next cycle vec=0, busy=0, no done pulse.
  - Then a fresh start completes normally with pass=1.
- Pulse start again while busy.
  - Required: ignored; done occurs exactly once at the original start+8·HOLD_CYCLES+1.
